// File: rtl/sys_defs.sv
// Shared types and sizes for the dispatch-side branch tag allocator and branch stack.
// Latency: none (types, constants and a helper function only).
// Backpressure: none.
package sys_defs;

   localparam int XLEN             = 32;
   localparam int B_MASK_WIDTH     = 4;   // power of two; the tag picker relies on natural wrap
   localparam int ARCH_REG_SZ_R10K = 32;
   localparam int PHYS_REG_SZ_R10K = 64;
   localparam int ROB_SZ           = 32;
   localparam int ROB_SZ_BITS      = $clog2(ROB_SZ);
   localparam int SQ_SZ            = 8;

   typedef logic [XLEN-1:0]                     ADDR;
   typedef logic [B_MASK_WIDTH-1:0]             B_MASK;
   typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PHYS_REG_IDX;
   typedef logic [$clog2(SQ_SZ)-1:0]            SQ_POINTER;
   typedef logic [SQ_SZ-1:0]                    SQ_MASK;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } ALLOC_STATE_T;

   // Predictor state carried with a branch so a mispredict can repair it.
   typedef struct packed {
      logic       taken;
      logic [1:0] ctr;
      logic [7:0] ghist;
      ADDR        target;
   } BRANCH_PREDICTOR_PACKET;

   // One checkpoint of the branch stack.
   typedef struct packed {
      B_MASK                                 b_m;
      ADDR                                   original_PC;
      ADDR                                   recovery_PC;
      logic                                  is_jump;
      BRANCH_PREDICTOR_PACKET                bp_packet;
      PHYS_REG_IDX [ARCH_REG_SZ_R10K-1:0]    map_table;
      logic [PHYS_REG_SZ_R10K-1:0]           free_list;
      logic [ROB_SZ_BITS-1:0]                rob_tail;
      SQ_POINTER                             sq_tail;
      SQ_MASK                                sq_mask;
   } BS_ENTRY_PACKET;

   function automatic logic [31:0] popcount(input B_MASK m);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
         n = n + 32'(m[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rr_tag_picker.sv
// Rotating priority encoder: lowest free tag at or after rr_ptr, wrapping.
// Latency: combinational. Backpressure: none; tag_vld=0 when no tag is free.
// Ports: free_mask/rr_ptr in; tag_oh (one-hot), tag_idx, tag_vld out.
module rr_tag_picker
   import sys_defs::*;
#(
   parameter int N = B_MASK_WIDTH
) (
   input  logic [N-1:0]         free_mask,
   input  logic [$clog2(N)-1:0] rr_ptr,
   output logic [N-1:0]         tag_oh,
   output logic [$clog2(N)-1:0] tag_idx,
   output logic                 tag_vld
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] cand;

   always_comb begin
      tag_oh  = '0;
      tag_idx = '0;
      tag_vld = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         // N is a power of two, so the PW-bit add wraps modulo N by itself.
         cand = rr_ptr + PW'(k);
         if (!tag_vld && free_mask[cand]) begin
            tag_vld      = 1'b1;
            tag_idx      = cand;
            tag_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/branch_tag_alloc.sv
// Branch tag allocator: grants one branch-mask tag per cycle, builds its checkpoint, tags slots.
// Latency: all outputs combinational from current state and inputs; state updates next edge.
// Backpressure: dispatch_count cuts dispatch at a second branch, a tagless branch, or recovery.
// Ports: dispatch slot inputs (valid/branch/jump/PC/predictor/rename snapshots), b_mm_resolved,
//   restore_valid in; dispatch_count, inst_b_mask, inst_b_mm, next_b_mask, branch_stack_entries,
//   tags_full out. Define BRANCH_TAG_ALLOC_STATS_EN to add stat_allocs, stat_full_stalls,
//   stat_squashed_tags (32-bit saturating, cleared on reset).
module branch_tag_alloc
   import sys_defs::*;
#(
   parameter int DISPATCH_WIDTH = 2,
   parameter int RECOVER_CYCLES = 1
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [DISPATCH_WIDTH-1:0]          inst_valid,
   input  logic [DISPATCH_WIDTH-1:0]          is_branch,
   input  logic [DISPATCH_WIDTH-1:0]          is_jump,
   input  ADDR                                inst_PC        [DISPATCH_WIDTH],
   input  BRANCH_PREDICTOR_PACKET             bp_packet_in   [DISPATCH_WIDTH],
   input  PHYS_REG_IDX [ARCH_REG_SZ_R10K-1:0] map_table_in   [DISPATCH_WIDTH],
   input  logic [PHYS_REG_SZ_R10K-1:0]        free_list_in   [DISPATCH_WIDTH],
   input  logic [ROB_SZ_BITS-1:0]             rob_tail_in    [DISPATCH_WIDTH],
   input  SQ_POINTER                          sq_tail_in     [DISPATCH_WIDTH],
   input  SQ_MASK                             sq_mask_in     [DISPATCH_WIDTH],
   input  B_MASK                              b_mm_resolved,
   input  logic                               restore_valid,
   output logic [$clog2(DISPATCH_WIDTH+1)-1:0] dispatch_count,
   output B_MASK                              inst_b_mask    [DISPATCH_WIDTH],
   output B_MASK                              inst_b_mm      [DISPATCH_WIDTH],
   output B_MASK                              next_b_mask,
   output BS_ENTRY_PACKET                     branch_stack_entries [B_MASK_WIDTH],
   output logic                               tags_full
`ifdef BRANCH_TAG_ALLOC_STATS_EN
   ,
   output logic [31:0]                        stat_allocs,
   output logic [31:0]                        stat_full_stalls,
   output logic [31:0]                        stat_squashed_tags
`endif
);

   localparam int CNT_W  = $clog2(DISPATCH_WIDTH + 1);
   localparam int PTR_W  = $clog2(B_MASK_WIDTH);
   localparam int SLOT_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;
   localparam int RC_W   = 2;   // recovery window is 1..3 cycles

   // ---------------- state ----------------
   ALLOC_STATE_T       state_q, state_d;
   logic [RC_W-1:0]    recover_cnt_q, recover_cnt_d;
   B_MASK              active_mask_q, active_mask_d;
   B_MASK              dep_mask_q [B_MASK_WIDTH];
   B_MASK              dep_mask_d [B_MASK_WIDTH];
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   // ---------------- resolve / squash ----------------
   B_MASK resolved;   // resolving tag, ignored unless it is actually in flight
   B_MASK squashed;   // victim plus every younger tag on a restore
   B_MASK eff_mask;
   B_MASK free_mask;

   always_comb begin
      resolved = b_mm_resolved & active_mask_q;
      squashed = '0;
      if (restore_valid) begin
         squashed = resolved;
         for (int j = 0; j < B_MASK_WIDTH; j++) begin
            // A tag is younger than the victim iff it was allocated while the victim was live.
            if (active_mask_q[j] && |(dep_mask_q[j] & resolved)) begin
               squashed[j] = 1'b1;
            end
         end
      end
      eff_mask  = active_mask_q & ~(resolved | squashed);
      free_mask = ~eff_mask;
   end

   // ---------------- tag pick ----------------
   B_MASK            pick_oh;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_vld;

   rr_tag_picker #(
      .N (B_MASK_WIDTH)
   ) u_picker (
      .free_mask (free_mask),
      .rr_ptr    (rr_ptr_q),
      .tag_oh    (pick_oh),
      .tag_idx   (pick_idx),
      .tag_vld   (pick_vld)
   );

   // ---------------- slot scan ----------------
   logic              hold;
   logic              grant;
   logic [SLOT_W-1:0] grant_slot;
   logic              seen_branch;
   logic              limited;
   B_MASK             grant_oh;

   always_comb begin
      grant          = 1'b0;
      grant_slot     = '0;
      seen_branch    = 1'b0;
      limited        = 1'b0;
      dispatch_count = CNT_W'(DISPATCH_WIDTH);
      for (int s = 0; s < DISPATCH_WIDTH; s++) begin
         if (!limited && inst_valid[s] && is_branch[s]) begin
            if (seen_branch) begin
               // Only one checkpoint per cycle: the second branch waits.
               dispatch_count = CNT_W'(s);
               limited        = 1'b1;
            end else begin
               seen_branch = 1'b1;
               if (pick_vld) begin
                  grant      = 1'b1;
                  grant_slot = SLOT_W'(s);
               end else begin
                  dispatch_count = CNT_W'(s);
                  limited        = 1'b1;
               end
            end
         end
      end
      // A restore this cycle, or the recovery window after it, blocks all dispatch.
      hold = (state_q == RECOVER) || restore_valid;
      if (hold) begin
         grant          = 1'b0;
         dispatch_count = '0;
      end
      grant_oh = grant ? pick_oh : '0;
   end

   // ---------------- per-slot masks and stack outputs ----------------
   BS_ENTRY_PACKET new_entry;

   always_comb begin
      for (int s = 0; s < DISPATCH_WIDTH; s++) begin
         inst_b_mask[s] = eff_mask;
         inst_b_mm[s]   = '0;
         if (grant && (s > int'(grant_slot))) begin
            inst_b_mask[s] = eff_mask | grant_oh;
         end
         if (grant && (s == int'(grant_slot))) begin
            inst_b_mm[s] = grant_oh;
         end
      end

      next_b_mask = eff_mask | grant_oh;
      tags_full   = &eff_mask;

      new_entry             = '0;
      new_entry.b_m         = eff_mask;
      new_entry.original_PC = inst_PC[grant_slot];
      new_entry.recovery_PC = inst_PC[grant_slot] + 32'd4;
      new_entry.is_jump     = is_jump[grant_slot];
      new_entry.bp_packet   = bp_packet_in[grant_slot];
      new_entry.map_table   = map_table_in[grant_slot];
      new_entry.free_list   = free_list_in[grant_slot];
      new_entry.rob_tail    = rob_tail_in[grant_slot];
      new_entry.sq_tail     = sq_tail_in[grant_slot];
      new_entry.sq_mask     = sq_mask_in[grant_slot];

      for (int i = 0; i < B_MASK_WIDTH; i++) begin
         branch_stack_entries[i] = '0;
      end
      if (grant) begin
         branch_stack_entries[pick_idx] = new_entry;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      active_mask_d = next_b_mask;
      for (int j = 0; j < B_MASK_WIDTH; j++) begin
         dep_mask_d[j] = dep_mask_q[j] & ~resolved;
         if (resolved[j] || squashed[j]) begin
            dep_mask_d[j] = '0;
         end
         if (grant && (pick_idx == PTR_W'(j))) begin
            dep_mask_d[j] = eff_mask;
         end
      end

      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (pick_idx == PTR_W'(B_MASK_WIDTH - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      recover_cnt_d = recover_cnt_q;
      case (state_q)
         RUN: begin
            if (restore_valid) begin
               state_d       = RECOVER;
               recover_cnt_d = RC_W'(RECOVER_CYCLES);
            end
         end
         RECOVER: begin
            if (restore_valid) begin
               recover_cnt_d = RC_W'(RECOVER_CYCLES);
            end else if (recover_cnt_q <= RC_W'(1)) begin
               state_d       = RUN;
               recover_cnt_d = '0;
            end else begin
               recover_cnt_d = recover_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d       = RUN;
            recover_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= RUN;
         recover_cnt_q <= '0;
         active_mask_q <= '0;
         rr_ptr_q      <= '0;
         for (int j = 0; j < B_MASK_WIDTH; j++) begin
            dep_mask_q[j] <= '0;
         end
      end else begin
         state_q       <= state_d;
         recover_cnt_q <= recover_cnt_d;
         active_mask_q <= active_mask_d;
         rr_ptr_q      <= rr_ptr_d;
         for (int j = 0; j < B_MASK_WIDTH; j++) begin
            dep_mask_q[j] <= dep_mask_d[j];
         end
      end
   end

`ifdef BRANCH_TAG_ALLOC_STATS_EN
   // ---------------- statistics ----------------
   logic [31:0] stat_allocs_q, stat_allocs_d;
   logic [31:0] stat_full_stalls_q, stat_full_stalls_d;
   logic [31:0] stat_squashed_tags_q, stat_squashed_tags_d;
   logic        full_stall;
   logic [32:0] sq_sum;

   always_comb begin
      // Only the first branch of a cycle can be denied for lack of a tag.
      full_stall = !hold && (|(inst_valid & is_branch)) && !pick_vld;

      stat_allocs_d = stat_allocs_q;
      if (grant && (stat_allocs_q != '1)) begin
         stat_allocs_d = stat_allocs_q + 32'd1;
      end
      stat_full_stalls_d = stat_full_stalls_q;
      if (full_stall && (stat_full_stalls_q != '1)) begin
         stat_full_stalls_d = stat_full_stalls_q + 32'd1;
      end
      sq_sum               = {1'b0, stat_squashed_tags_q} + {1'b0, popcount(squashed)};
      stat_squashed_tags_d = sq_sum[32] ? '1 : sq_sum[31:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_allocs_q        <= '0;
         stat_full_stalls_q   <= '0;
         stat_squashed_tags_q <= '0;
      end else begin
         stat_allocs_q        <= stat_allocs_d;
         stat_full_stalls_q   <= stat_full_stalls_d;
         stat_squashed_tags_q <= stat_squashed_tags_d;
      end
   end

   assign stat_allocs        = stat_allocs_q;
   assign stat_full_stalls   = stat_full_stalls_q;
   assign stat_squashed_tags = stat_squashed_tags_q;
`endif

endmodule
